snake_game_sched: RTL and testbench

- Sequencer for the snake game datapath.
- Decodes PS/2 make-codes into a game FSM (idle/run/pause/over).
- Generates the single-cycle movement-step strobe from the 100 MHz clock.
- Buffers arrow presses in a small direction queue, so fast double-taps within one tick are not lost and reversals are rejected.
- Sits between the keyboard receiver and the snake position/collision datapath.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_dir_fifo.sv | 57 +++++
 rtl/snake_game_sched.sv | 160 ++++++++++++++++
 tb/tb_snake_game_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants, state encoding and direction helpers for the snake sequencer.
package snake_pkg;

    localparam int unsigned CODE_W       = 8;
    localparam int unsigned TICK_DIV_DEF = 1666667;
    // Tick counter width; sized for the 60 Hz default and any smaller divider.
    localparam int unsigned CNT_W        = $clog2(TICK_DIV_DEF);

    localparam logic [CODE_W-1:0] KEY_S   = 8'h1B;
    localparam logic [CODE_W-1:0] KEY_P   = 8'h4D;
    localparam logic [CODE_W-1:0] KEY_R   = 8'h2D;
    localparam logic [CODE_W-1:0] KEY_ESC = 8'h76;
    localparam logic [CODE_W-1:0] KEY_UP  = 8'h75;
    localparam logic [CODE_W-1:0] KEY_DN  = 8'h72;
    localparam logic [CODE_W-1:0] KEY_LF  = 8'h6B;
    localparam logic [CODE_W-1:0] KEY_RT  = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    function automatic logic is_opposite(input logic [CODE_W-1:0] a, input logic [CODE_W-1:0] b);
        return ((a == KEY_UP) && (b == KEY_DN)) || ((a == KEY_DN) && (b == KEY_UP)) ||
               ((a == KEY_LF) && (b == KEY_RT)) || ((a == KEY_RT) && (b == KEY_LF));
    endfunction

    function automatic logic is_arrow(input logic [CODE_W-1:0] c);
        return (c == KEY_UP) || (c == KEY_DN) || (c == KEY_LF) || (c == KEY_RT);
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Small direction queue; silently drops duplicates, reversals and pushes when full.
module snake_dir_fifo
    import snake_pkg::*;
#(
    parameter int unsigned Q_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_push_req,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_pop,
    input  logic [CODE_W-1:0] i_dir_cur,
    output logic [CODE_W-1:0] o_head,
    output logic [CODE_W-1:0] o_tail,
    output logic              o_empty,
    output logic              o_full
);

    localparam int unsigned AW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [CODE_W-1:0] r_mem [Q_DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_cnt;
    logic [CODE_W-1:0] w_ref;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(Q_DEPTH));
    assign o_head  = r_mem[r_rd];
    assign o_tail  = r_mem[r_wr - AW'(1)];

    // New heading is judged against the last queued move, or the live heading if none.
    assign w_ref  = o_empty ? i_dir_cur : o_tail;
    assign w_push = i_push_req && !o_full && (i_code != w_ref) && !is_opposite(i_code, w_ref);
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_code;
    end

endmodule

// File: rtl/snake_game_sched.sv
// Game FSM, movement tick and key decode for the snake datapath.
// Define SNAKE_SCHED_SPEEDUP_EN to shorten the step period on every grow pulse.
module snake_game_sched
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1666667,
    parameter int unsigned Q_DEPTH  = 2,
    parameter int unsigned TICK_DEC = 50000,
    parameter int unsigned TICK_MIN = 416667
) (
    input  logic              clk100Mhz,
    input  logic              rst,
    input  logic [CODE_W-1:0] key_code,
    input  logic              key_valid,
    input  logic              game_over,
    input  logic              grow,
    output logic [1:0]        game_state,
    output logic              step_en,
    output logic [CODE_W-1:0] dir,
    output logic              init_pulse
);

    game_state_e       r_state;
    game_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_step;
    logic              r_init;
    logic [CODE_W-1:0] r_dir;

    logic              w_key_esc;
    logic              w_key_s;
    logic              w_key_p;
    logic              w_key_r;
    logic              w_key_arrow;
    logic              w_start;
    logic              w_adv;
    logic              w_flush;
    logic              w_step;
    logic              w_tc;
    logic [CNT_W-1:0]  w_last;
    logic [CODE_W-1:0] w_q_head;
    logic              w_q_empty;
    logic [CODE_W-1:0] w_q_tail_unused;
    logic              w_q_full_unused;

    assign w_key_esc   = key_valid && (key_code == KEY_ESC);
    assign w_key_s     = key_valid && (key_code == KEY_S);
    assign w_key_p     = key_valid && (key_code == KEY_P);
    assign w_key_r     = key_valid && (key_code == KEY_R);
    assign w_key_arrow = key_valid && is_arrow(key_code);

    always_ff @(posedge clk100Mhz) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_key_esc) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_key_s) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (game_over)    w_state_nxt = ST_OVER;
                    else if (w_key_p) w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (w_key_r) w_state_nxt = ST_RUN;
                ST_OVER:  if (w_key_s) w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Datapath controls: a collision in RUN freezes the tick and kills any step.
    always_comb begin
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_flush = w_key_esc;
        case (r_state)
            ST_IDLE:  w_start = w_key_s;
            ST_OVER:  w_start = w_key_s;
            ST_RUN: begin
                w_adv   = !w_key_esc && !game_over;
                w_flush = w_key_esc || game_over;
            end
            ST_PAUSE: ;
        endcase
        w_flush = w_flush || w_start;
    end

`ifdef SNAKE_SCHED_SPEEDUP_EN
    localparam logic [CNT_W-1:0] C_DIV = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0] C_DEC = CNT_W'(TICK_DEC);
    localparam logic [CNT_W-1:0] C_MIN = CNT_W'(TICK_MIN);

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_period_cur;

    // r_period collects grow requests; r_period_cur only changes at a wrap.
    always_ff @(posedge clk100Mhz) begin
        if (rst || w_start) begin
            r_period     <= C_DIV;
            r_period_cur <= C_DIV;
        end else begin
            if (w_step) r_period_cur <= r_period;
            if (w_adv && grow) begin
                r_period <= ((r_period > C_MIN) && ((r_period - C_MIN) > C_DEC))
                            ? (r_period - C_DEC) : C_MIN;
            end
        end
    end

    assign w_last = r_period_cur - CNT_W'(1);
`else
    logic [1:0] w_cfg_unused;
    assign w_cfg_unused = {grow, (TICK_DEC > TICK_MIN)};
    assign w_last       = CNT_W'(TICK_DIV - 1);
`endif

    assign w_tc   = (r_cnt == w_last);
    assign w_step = w_adv && w_tc;

    snake_dir_fifo #(
        .Q_DEPTH (Q_DEPTH)
    ) u_dir_fifo (
        .i_clk      (clk100Mhz),
        .i_rst      (rst),
        .i_flush    (w_flush),
        .i_push_req (w_adv && w_key_arrow),
        .i_code     (key_code),
        .i_pop      (w_step),
        .i_dir_cur  (r_dir),
        .o_head     (w_q_head),
        .o_tail     (w_q_tail_unused),
        .o_empty    (w_q_empty),
        .o_full     (w_q_full_unused)
    );

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
            r_init <= 1'b0;
            r_dir  <= KEY_RT;
        end else begin
            r_step <= w_step;
            r_init <= w_start;
            if (w_key_esc || w_start) r_cnt <= '0;
            else if (w_adv)           r_cnt <= w_tc ? '0 : (r_cnt + CNT_W'(1));
            if (w_start)                   r_dir <= KEY_RT;
            else if (w_step && !w_q_empty) r_dir <= w_q_head;
        end
    end

    assign game_state = r_state;
    assign step_en    = r_step;
    assign dir        = r_dir;
    assign init_pulse = r_init;

endmodule

// File: tb/tb_snake_game_sched.sv
// Self-checking bench for snake_game_sched: vector table, directed corner cases, random run.
module tb_snake_game_sched;

    localparam int unsigned TD   = 4;
    localparam int unsigned QD   = 2;
    localparam int unsigned TDEC = 1;
    localparam int unsigned TMIN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_code;
    logic       key_valid;
    logic       game_over;
    logic       grow;
    logic [1:0] game_state;
    logic       step_en;
    logic [7:0] dir;
    logic       init_pulse;

    always #5 clk = ~clk;

    snake_game_sched #(
        .TICK_DIV (TD),
        .Q_DEPTH  (QD),
        .TICK_DEC (TDEC),
        .TICK_MIN (TMIN)
    ) dut (
        .clk100Mhz  (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .game_over  (game_over),
        .grow       (grow),
        .game_state (game_state),
        .step_en    (step_en),
        .dir        (dir),
        .init_pulse (init_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: game state, tick count and a queue of pending headings.
    int         m_state;
    int         m_cnt;
    int         m_cur;
    int         m_pend;
    logic [7:0] m_dir;
    logic [7:0] m_q[$];
    logic       e_step;
    logic       e_init;

    int         cyc_n = 0;
    int         n_steps = 0;
    int         init_at = 0;
    int         step_at[$];
    logic [7:0] last_dir = 8'h00;

    typedef struct {
        logic       kv;
        logic [7:0] kc;
        logic [1:0] e_state;
        logic       e_step;
        logic [7:0] e_dir;
        logic       e_init;
    } vec_t;
    vec_t tbl[13];

    function automatic logic [7:0] opp(input logic [7:0] c);
        case (c)
            8'h75:   return 8'h72;
            8'h72:   return 8'h75;
            8'h6B:   return 8'h74;
            8'h74:   return 8'h6B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_dir   = 8'h74;
        m_q.delete();
        m_cur   = TD;
        m_pend  = TD;
        e_step  = 1'b0;
        e_init  = 1'b0;
    endtask

    task automatic model_edge(input logic kv, input logic [7:0] kc, input logic go, input logic gr);
        logic [7:0] rf;
        logic       acc;
        e_step = 1'b0;
        e_init = 1'b0;
        if (kv && kc == 8'h76) begin
            m_state = 0;
            m_q.delete();
            m_cnt = 0;
            return;
        end
        case (m_state)
            0, 3: begin
                if (kv && kc == 8'h1B) begin
                    m_state = 1;
                    e_init  = 1'b1;
                    m_dir   = 8'h74;
                    m_q.delete();
                    m_cnt   = 0;
                    m_cur   = TD;
                    m_pend  = TD;
                end
            end
            1: begin
                if (go) begin
                    m_state = 3;
                    m_q.delete();
                end else begin
                    rf  = (m_q.size() > 0) ? m_q[$] : m_dir;
                    acc = kv && (opp(kc) != 8'h00) && (kc != rf) && (kc != opp(rf)) && (m_q.size() < QD);
                    if (m_cnt == m_cur - 1) begin
                        e_step = 1'b1;
                        m_cnt  = 0;
                        if (m_q.size() > 0) m_dir = m_q.pop_front();
`ifdef SNAKE_SCHED_SPEEDUP_EN
                        m_cur = m_pend;
`endif
                    end else begin
                        m_cnt++;
                    end
                    if (acc) m_q.push_back(kc);
                    if (gr) m_pend = (m_pend - int'(TDEC) < int'(TMIN)) ? int'(TMIN) : m_pend - int'(TDEC);
                    if (kv && kc == 8'h4D) m_state = 2;
                end
            end
            2: if (kv && kc == 8'h2D) m_state = 1;
            default: ;
        endcase
    endtask

    // One clock: drive, let the edge happen, advance the model, compare 1 ns later.
    task automatic cyc(input logic r, input logic kv, input logic [7:0] kc, input logic go, input logic gr);
        rst       = r;
        key_valid = kv;
        key_code  = kc;
        game_over = go;
        grow      = gr;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(kv, kc, go, gr);
        cyc_n++;
        #1;
        chk("game_state", 32'(game_state), 32'(m_state));
        chk("step_en", 32'(step_en), 32'(e_step));
        chk("init_pulse", 32'(init_pulse), 32'(e_init));
        chk("dir", 32'(dir), 32'(m_dir));
        if (step_en) begin
            n_steps++;
            last_dir = dir;
            step_at.push_back(cyc_n);
        end
        if (init_pulse) init_at = cyc_n;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [7:0] c);
        cyc(1'b0, 1'b1, c, 1'b0, 1'b0);
    endtask

    initial begin
        int         s0;
        logic       g;
        logic [7:0] codes[15];

        for (int i = 0; i < 13; i++) begin
            tbl[i].kv      = (i == 0);
            tbl[i].kc      = (i == 0) ? 8'h1B : 8'h00;
            tbl[i].e_state = 2'd1;
            tbl[i].e_step  = (i > 0) && (i % 4 == 0);
            tbl[i].e_dir   = 8'h74;
            tbl[i].e_init  = (i == 0);
        end

        // Reset values
        cyc(1'b1, 1'b1, 8'h1B, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_step", 32'(step_en), 32'd0);
        chk("rst_dir", 32'(dir), 32'h74);
        chk("rst_init", 32'(init_pulse), 32'd0);

        // Start and first three steps
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, tbl[i].kv, tbl[i].kc, 1'b0, 1'b0);
            chk("tbl_state", 32'(game_state), 32'(tbl[i].e_state));
            chk("tbl_step", 32'(step_en), 32'(tbl[i].e_step));
            chk("tbl_dir", 32'(dir), 32'(tbl[i].e_dir));
            chk("tbl_init", 32'(init_pulse), 32'(tbl[i].e_init));
        end

        // Two arrows inside one tick are both kept; a later reversal is dropped
        s0 = n_steps;
        key(8'h75);
        key(8'h6B);
        idle(2);
        chk("dbl_tap_step1", 32'(n_steps - s0), 32'd1);
        chk("dbl_tap_dir1", 32'(last_dir), 32'h75);
        idle(4);
        chk("dbl_tap_dir2", 32'(last_dir), 32'h6B);
        key(8'h74);
        idle(3);
        chk("reverse_drop_dir", 32'(last_dir), 32'h6B);
        chk("reverse_drop_steps", 32'(n_steps - s0), 32'd3);

        // Reverse and duplicate rejected, valid turn taken at the next step
        key(8'h76);
        chk("esc_idle", 32'(game_state), 32'd0);
        key(8'h1B);
        s0 = n_steps;
        key(8'h6B);
        key(8'h74);
        key(8'h75);
        idle(1);
        chk("filter_step", 32'(n_steps - s0), 32'd1);
        chk("filter_dir", 32'(last_dir), 32'h75);

        // Pause one cycle before terminal count; ignored inputs while paused
        idle(2);
        key(8'h4D);
        s0 = n_steps;
        for (int i = 0; i < 20; i++) begin
            case (i)
                3:       key(8'h6B);
                7:       key(8'h1B);
                11:      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
                default: idle(1);
            endcase
        end
        chk("pause_state", 32'(game_state), 32'd2);
        chk("pause_no_step", 32'(n_steps - s0), 32'd0);
        key(8'h2D);
        chk("resume_state", 32'(game_state), 32'd1);
        chk("resume_no_step_yet", 32'(step_en), 32'd0);
        idle(1);
        chk("resume_step", 32'(step_en), 32'd1);
        chk("resume_dir", 32'(dir), 32'h75);

        // game_over beats P and the terminal-count step
        idle(3);
        cyc(1'b0, 1'b1, 8'h4D, 1'b1, 1'b0);
        chk("over_state", 32'(game_state), 32'd3);
        chk("over_step", 32'(step_en), 32'd0);
        key(8'h1B);
        chk("restart_init", 32'(init_pulse), 32'd1);
        chk("restart_state", 32'(game_state), 32'd1);
        chk("restart_dir", 32'(dir), 32'h74);

`ifdef SNAKE_SCHED_SPEEDUP_EN
        // Three grow pulses shrink the spacing to the floor
        key(8'h76);
        key(8'h1B);
        step_at.delete();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        g = 1'b0;
        for (int i = 0; i < 20 && step_at.size() < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, g);
            g = e_step && (step_at.size() < 3);
        end
        chk("speedup_steps", 32'(step_at.size()), 32'd4);
        if (step_at.size() >= 4) begin
            chk("speedup_gap0", 32'(step_at[0] - init_at), 32'd4);
            chk("speedup_gap1", 32'(step_at[1] - step_at[0]), 32'd3);
            chk("speedup_gap2", 32'(step_at[2] - step_at[1]), 32'd2);
            chk("speedup_gap3", 32'(step_at[3] - step_at[2]), 32'd2);
        end
`endif

        // ESC flushes a queued turn; restart returns to the base spacing
        key(8'h75);
        key(8'h76);
        chk("esc_flush_state", 32'(game_state), 32'd0);
        key(8'h1B);
        step_at.delete();
        idle(4);
        chk("restart_steps", 32'(step_at.size()), 32'd1);
        if (step_at.size() >= 1) chk("restart_gap", 32'(step_at[0] - init_at), 32'(TD));
        chk("restart_flush_dir", 32'(last_dir), 32'h74);

        // Random traffic against the model
        codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h6B, 8'h74,
                  8'h1B, 8'h1B, 8'h4D, 8'h2D, 8'h2D, 8'h76, 8'h00};
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       kv;
            logic [7:0] kc;
            logic       go;
            logic       gr;
            r  = ($urandom_range(0, 199) == 0);
            kv = ($urandom_range(0, 2) == 0);
            kc = codes[$urandom_range(0, 14)];
            if (kc == 8'h00) kc = 8'($urandom);
            go = ($urandom_range(0, 39) == 0);
            gr = ($urandom_range(0, 7) == 0);
            cyc(r, kv, kc, go, gr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
